dp_ctrl: RTL and testbench
==========================

# dp_ctrl

Sequencing controller for the register-file datapath. Accepts one 16-bit instruction per transaction over a valid/ready handshake, decodes it, and drives the 8×16 register file, the A/B/C pipeline registers, the shifter, the ALU and the status register through a Moore state machine. Asserts a one-cycle `done` when the instruction has retired. It sits between the instruction source (test harness now, fetch unit later) and the datapath.

## Interface
Parameters: none. Widths are fixed by the datapath: 16-bit data, 3-bit register index.

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  instruction present on `instr`
- `instr`  in  16  instruction word
- `in_ready`  out  1  controller idle, can accept
- `done`  out  1  one-cycle retire pulse
- `err`  out  1  qualifies `done`: illegal instruction
- `readnum`  out  3  register file read index
- `writenum`  out  3  register file write index
- `write`  out  1  register file write enable
- `loada`, `loadb`, `loadc`, `loads`  out  1 each  A/B/C/status register enables
- `asel`  out  1  1 = ALU A input forced to 0
- `bsel`  out  1  1 = ALU B input from `sximm8` (unused, held 0)
- `vsel`  out  2  write-back source: 00 = C, 01 = `sximm8`
- `shift`  out  2  shifter op on B
- `ALUop`  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT-B
- `sximm8`  out  16  sign-extended `instr[7:0]` of the latched instruction

## Operation
- Fields of the latched instruction: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
- Supported instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,sh(Rm)
  - 101/01 CMP Rn,sh(Rm)
  - 101/10 AND Rd,Rn,sh(Rm)
  - 101/11 MVN Rd,sh(Rm)
  - Every other opcode/op combination is illegal.
- States: IDLE, DECODE, WR_IMM, LD_A, LD_B, EXEC, WR_C, DONE.
- IDLE: `in_ready`=1. When `in_valid`=1, latch `instr` and go to DECODE.
- DECODE routes by instruction:
  - MOV imm → WR_IMM
  - MOV reg, MVN → LD_B
  - ADD, AND, CMP → LD_A
  - illegal → DONE with `err`
- WR_IMM: `writenum`=Rn, `vsel`=01, `write`=1 → DONE.
- LD_A: `readnum`=Rn, `loada`=1 → LD_B.
- LD_B: `readnum`=Rm, `loadb`=1 → EXEC.
- EXEC drives:
  - `ALUop` = op for 101 instructions; 00 for MOV reg.
  - `asel`=1 for MOV reg and MVN.
  - `loadc`=1 for all except CMP.
  - `loads`=1 for CMP only.
  - Next state: CMP → DONE, all others → WR_C.
- WR_C: `writenum`=Rd, `vsel`=00, `write`=1 → DONE.
- DONE: `done`=1; `err`=1 if the latched instruction is illegal → IDLE.
- `shift` = latched sh in LD_B and EXEC, 00 elsewhere. MOV imm does not use `shift`.
- Any output not listed for a state is 0 in that state.

## Timing
- Reset (asynchronous, immediate): state = IDLE, latched instruction = 0. All outputs are 0 except `in_ready`=1.
- Reset mid-instruction abandons it. No `done` is produced. Any write already performed stands.
- Accept happens on the edge where `in_valid`=1 and `in_ready`=1. `in_valid`/`instr` are ignored in every other state.
- `in_ready` is low from DECODE through DONE. The earliest next accept is the edge that ends the first IDLE cycle after DONE.
- Cycles from the accept edge to the edge ending DONE:
  - MOV imm: 3
  - CMP: 5
  - MOV reg, MVN: 5
  - ADD, AND: 6
  - illegal: 2
- Register file write occurs at the edge ending WR_IMM/WR_C, one cycle before `done`.
- All outputs are pure functions of state plus the latched instruction. No combinational path from `in_valid`/`instr` to any output other than through the latch.

## Structure
- Package `dp_ctrl_pkg` holds:
  - state enum
  - opcode constants (`OPC_MOV`=3'b110, `OPC_ALU`=3'b101)
  - op codes
  - `VSEL_C`/`VSEL_IMM`
  - ALUop constants
- Sub-module `dp_ctrl_dec`: combinational decode of the latched word. Produces the field slices, `sximm8`, an instruction class (MOVI/MOVR/ADD/CMP/AND/MVN/ILL) and `uses_a`.
- `dp_ctrl` holds the instruction register and the FSM.

## Test plan
- 0xD0FB (MOV R0,#-5) → WR_IMM cycle: `write`=1, `writenum`=0, `vsel`=01, `sximm8`=0xFFFB. `done` the next cycle, 3 cycles total.
- 0xA148 (ADD R2,R1,R0 LSL) → states in order:
  - LD_A: `readnum`=1, `loada`=1
  - LD_B: `readnum`=0, `loadb`=1, `shift`=01
  - EXEC: `ALUop`=00, `loadc`=1
  - WR_C: `writenum`=2, `write`=1
  - `done` at cycle 6.
- 0xAB04 (CMP R3,R4) → EXEC: `ALUop`=01, `loads`=1, `loadc`=0. No `write` in any cycle. `done` at cycle 5.
- 0xB8E1 (MVN R7,R1) → no LD_A. EXEC: `asel`=1, `ALUop`=11. WR_C: `writenum`=7.
- 0x0000 (illegal) → `done`=1 and `err`=1 two cycles after accept. No load or write asserted at any point.
- The following must all hold:
  - `in_valid` held high across back-to-back instructions is accepted only in IDLE.
  - `reset_n` pulsed low during LD_B forces all outputs to 0 immediately, with no `done`.
  - After `reset_n` is released, `in_ready`=1.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared types and encodings for the register-file datapath sequencer.
// Field positions and control encodings are fixed by the datapath.
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WR_IMM,
        S_LD_A,
        S_LD_B,
        S_EXEC,
        S_WR_C,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_MOVI,
        CLS_MOVR,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_MVN,
        CLS_ILL
    } instr_class_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b01;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/dp_ctrl_dec.sv
// Combinational decode of the latched instruction word into fields,
// the sign-extended immediate and an instruction class.
module dp_ctrl_dec
    import dp_ctrl_pkg::*;
(
    input  logic [15:0]  ir,
    output logic [1:0]   op,
    output logic [2:0]   rn,
    output logic [2:0]   rd,
    output logic [1:0]   sh,
    output logic [2:0]   rm,
    output logic [15:0]  sximm8,
    output instr_class_t cls,
    output logic         uses_a
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    always_comb begin
        cls = CLS_ILL;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)      cls = CLS_MOVI;
                else if (op == OP_MOV_REG) cls = CLS_MOVR;
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD:  cls = CLS_ADD;
                    OP_CMP:  cls = CLS_CMP;
                    OP_AND:  cls = CLS_AND;
                    default: cls = CLS_MVN;
                endcase
            end
            default: cls = CLS_ILL;
        endcase
    end

    // Two-operand instructions read Rn into A before Rm goes into B.
    assign uses_a = (cls == CLS_ADD) || (cls == CLS_CMP) || (cls == CLS_AND);

endmodule

// File: rtl/dp_ctrl.sv
// Moore sequencer for the register-file datapath: latches one instruction
// per valid/ready handshake and steps the datapath through its phases.
module dp_ctrl
    import dp_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [15:0] instr,
    output logic        in_ready,
    output logic        done,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8
);

    state_t       state, state_next;
    logic [15:0]  ir;
    logic [1:0]   op;
    logic [2:0]   rn, rd, rm;
    logic [1:0]   sh;
    instr_class_t cls;
    logic         uses_a;

    dp_ctrl_dec u_dec (
        .ir     (ir),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8),
        .cls    (cls),
        .uses_a (uses_a)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            // NOTE: the instruction register is reset so sximm8 and the
            // decode are defined (zero) out of reset, not just the FSM.
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && in_valid)
                ir <= instr;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first; any path that skips an
        // assignment would otherwise infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        readnum    = '0;
        writenum   = '0;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = VSEL_C;
        shift      = '0;
        ALUop      = ALU_ADD;

        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                if (cls == CLS_ILL)       state_next = S_DONE;
                else if (cls == CLS_MOVI) state_next = S_WR_IMM;
                else if (uses_a)          state_next = S_LD_A;
                else                      state_next = S_LD_B;
            end
            S_WR_IMM: begin
                writenum   = rn;
                vsel       = VSEL_IMM;
                write      = 1'b1;
                state_next = S_DONE;
            end
            S_LD_A: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = S_LD_B;
            end
            S_LD_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                shift      = sh;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                shift = sh;
                // MOV reg is computed as 0 + sh(Rm); the ALU ops map 1:1 onto op.
                ALUop = (cls == CLS_MOVR) ? ALU_ADD : op;
                asel  = (cls == CLS_MOVR) || (cls == CLS_MVN);
                loadc = (cls != CLS_CMP);
                loads = (cls == CLS_CMP);
                state_next = (cls == CLS_CMP) ? S_DONE : S_WR_C;
            end
            S_WR_C: begin
                writenum   = rd;
                vsel       = VSEL_C;
                write      = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                err        = (cls == CLS_ILL);
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dp_ctrl.sv
// Scoreboard bench for dp_ctrl: stimulus pushes hand-written per-cycle
// control traces; a negedge monitor pops and compares every busy cycle.
module tb_dp_ctrl;

    typedef struct packed {
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  vsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic        done;
        logic        err;
        logic [15:0] sximm8;
    } ctl_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] instr;
    logic        in_ready, done, err;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;
    ctl_t exp_q[$];
    ctl_t act;

    dp_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .instr    (instr),
        .in_ready (in_ready),
        .done     (done),
        .err      (err),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .ALUop    (ALUop),
        .sximm8   (sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb act = {readnum, writenum, write, loada, loadb, loadc, loads,
                       asel, bsel, vsel, shift, ALUop, done, err, sximm8};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // One expected control vector: rdn wrn wr la lb lc ls as vs sh alu dn er sx
    function automatic ctl_t c(input logic [2:0] rdn, input logic [2:0] wrn,
                               input logic wr, input logic la, input logic lb,
                               input logic lc, input logic ls, input logic as,
                               input logic [1:0] vs, input logic [1:0] sh,
                               input logic [1:0] alu, input logic dn,
                               input logic er, input logic [15:0] sx);
        c = '{rdn, wrn, wr, la, lb, lc, ls, as, 1'b0, vs, sh, alu, dn, er, sx};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (!in_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_busy_cycle", 64'(act), 64'hDEAD);
                end else begin
                    check("trace", 64'(act), 64'(exp_q.pop_front()));
                end
            end else begin
                ctl_t idle_v;
                idle_v = act;
                idle_v.sximm8 = '0;
                check("idle_outputs_zero", 64'(idle_v), 64'd0);
            end
        end
    end

    // Drive one instruction and return one cycle after its accept edge.
    task automatic send(input logic [15:0] w);
        int n = 0;
        in_valid = 1'b1;
        instr    = w;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        instr    = 16'h0000;
        #1;
        check("reset_outputs", 64'(act), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // MOV R0,#-5
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'hFFFB));
        exp_q.push_back(c(0,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,16'hFFFB));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,16'hFFFB));
        send(16'hD0FB);
        drain();

        // ADD R2,R1,R0 LSL
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0048));
        exp_q.push_back(c(1,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0048));
        exp_q.push_back(c(0,0,0,0,1,0,0,0,2'b00,2'b01,2'b00,0,0,16'h0048));
        exp_q.push_back(c(0,0,0,0,0,1,0,0,2'b00,2'b01,2'b00,0,0,16'h0048));
        exp_q.push_back(c(0,2,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0048));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,16'h0048));
        send(16'hA148);
        drain();

        // CMP R3,R4
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0004));
        exp_q.push_back(c(3,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0004));
        exp_q.push_back(c(4,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0004));
        exp_q.push_back(c(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b01,0,0,16'h0004));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,16'h0004));
        send(16'hAB04);
        drain();

        // MVN R7,R1
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'hFFE1));
        exp_q.push_back(c(1,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,16'hFFE1));
        exp_q.push_back(c(0,0,0,0,0,1,0,1,2'b00,2'b00,2'b11,0,0,16'hFFE1));
        exp_q.push_back(c(0,7,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'hFFE1));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,16'hFFE1));
        send(16'hB8E1);
        drain();

        // Illegal 0x0000
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0000));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1,16'h0000));
        send(16'h0000);
        drain();

        // MOV R3,R5,sh=10
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0075));
        exp_q.push_back(c(5,0,0,0,1,0,0,0,2'b00,2'b10,2'b00,0,0,16'h0075));
        exp_q.push_back(c(0,0,0,0,0,1,0,1,2'b00,2'b10,2'b00,0,0,16'h0075));
        exp_q.push_back(c(0,3,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0075));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,16'h0075));
        send(16'hC075);
        drain();

        // AND R4,R6,sh=11(R2)
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'hFF9A));
        exp_q.push_back(c(6,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'hFF9A));
        exp_q.push_back(c(2,0,0,0,1,0,0,0,2'b00,2'b11,2'b00,0,0,16'hFF9A));
        exp_q.push_back(c(0,0,0,0,0,1,0,0,2'b00,2'b11,2'b10,0,0,16'hFF9A));
        exp_q.push_back(c(0,4,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'hFF9A));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,16'hFF9A));
        send(16'hB69A);
        drain();

        // Illegal op under the MOV opcode (110/01)
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'hFFFF));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,1,16'hFFFF));
        send(16'hC8FF);
        drain();

        // in_valid held high: MOV R7,#0x7F, junk while busy, then CMP in IDLE
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h007F));
        exp_q.push_back(c(0,7,1,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,16'h007F));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,16'h007F));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0004));
        exp_q.push_back(c(3,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0004));
        exp_q.push_back(c(4,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0004));
        exp_q.push_back(c(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b01,0,0,16'h0004));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,16'h0004));
        in_valid = 1'b1;
        instr    = 16'hD77F;
        @(posedge clk); #1;
        instr = 16'h0000;
        begin
            int n = 0;
            while (!in_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("b2b_gap_cycles", 64'(n), 64'd3);
        end
        instr = 16'hAB04;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Reset pulsed during LD_B of an ADD
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0048));
        exp_q.push_back(c(1,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'h0048));
        send(16'hA148);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_reset_loadb", 64'(loadb), 64'd1);
        reset_n = 1'b0;
        #1;
        check("reset_async_outputs", 64'(act), 64'd0);
        check("reset_async_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        // Recovery after reset: MOV R0,#-5 again
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,16'hFFFB));
        exp_q.push_back(c(0,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,16'hFFFB));
        exp_q.push_back(c(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0,16'hFFFB));
        send(16'hD0FB);
        drain();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
